snitch_data_mem_bist: RTL
=========================

# snitch_data_mem_bist

Built-in self-test initiator for the cluster TCDM data memory. It drives the request side of all `NumTotalBanks` SRAM banks in parallel: chip select, write enable, address, byte enables and write data. It captures read data one cycle later and compares it against the expected pattern. It sits between the TCDM interconnect mux and the data memory, and owns the bank ports only while a test runs. It reports per-bank pass/fail and the first failing word address.

## Interface
Parameters:
- `TCDMDepth`, 1024, words per bank; must be a power of two, ≥ 2.
- `NarrowDataWidth`, 64, bank word width in bits; a multiple of 8.
- `NumTotalBanks`, 32, number of banks driven in parallel.
- `AddrWidth`, `$clog2(TCDMDepth)`, derived; do not override.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  start a test; sampled only in IDLE.
- `abort_i`  in  1  stop the test; honoured in any non-IDLE state.
- `pattern_i`  in  NarrowDataWidth  test word; latched on an accepted start.
- `busy_o`  out  1  high while state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when the results are final.
- `pass_o`  out  1  high when the last completed test had no mismatch.
- `fail_banks_o`  out  NumTotalBanks  sticky per-bank mismatch flags.
- `fail_addr_o`  out  AddrWidth  word address of the first mismatch.
- `mem_cs_o`  out  NumTotalBanks  bank chip selects.
- `mem_add_o`  out  NumTotalBanks×AddrWidth  bank addresses; all banks get the same value.
- `mem_wen_o`  out  NumTotalBanks  1 = write.
- `mem_be_o`  out  NumTotalBanks×NarrowDataWidth/8  byte enables.
- `mem_wdata_o`  out  NumTotalBanks×NarrowDataWidth  write data.
- `mem_rdata_i`  in  NumTotalBanks×NarrowDataWidth  read data, valid one cycle after a read request.

## Operation
States: IDLE, WR_PAT, RD_PAT, WR_INV, RD_INV, FLUSH.
- **IDLE:** `start_i` = 1 latches `pattern_i` into P, clears `fail_banks_o`, `fail_addr_o` and `pass_o`, loads address counter A = 0, and moves to WR_PAT.
- **WR_PAT:** ascending A = 0..D-1 (D = TCDMDepth). All banks write P at A. Moves to RD_PAT after A = D-1, with A reloaded to 0.
- **RD_PAT:** ascending reads at A; expected value is P. Moves to WR_INV after A = D-1.
- **WR_INV:** ascending writes of ~P at A. Moves to RD_INV after A = D-1, with A loaded to D-1.
- **RD_INV:** descending reads A = D-1..0; expected value is ~P. Moves to FLUSH after A = 0.
- **FLUSH:** no request. Performs the final compare, then returns to IDLE.

Request signals are decoded combinationally from the state and A:
- `mem_cs_o` = all ones in WR_/RD_ states, else 0.
- `mem_wen_o` = all ones in WR_ states, else 0.
- `mem_be_o` = all ones whenever `mem_cs_o` is high, else 0.
- `mem_wdata_o` = P or ~P during writes, 0 otherwise.

Compare pipeline:
- A read issue registers `cmp_vld` = 1, `cmp_exp` and `cmp_addr`.
- In the next cycle, every bank i with `mem_rdata_i[i]` ≠ `cmp_exp` sets `fail_banks_o[i]`.
- The first cycle with any mismatch while `fail_banks_o` is still zero loads `fail_addr_o` = `cmp_addr`. Later mismatches never change it.
- The compare runs regardless of the current state, including during the following write phase and during FLUSH.

Completion and control:
- Leaving FLUSH registers `done_o` = 1 for one cycle and sets `pass_o` = ~|`fail_banks_o` (including the FLUSH compare).
- `start_i` outside IDLE is ignored.
- `abort_i`: next state is IDLE, `cmp_vld` is cleared, no `done_o`, `pass_o` stays 0, and the fail registers hold their partial contents.
- `abort_i` takes priority over any state transition in the same cycle.

## Timing
- Reset values: state IDLE, `busy_o` 0, `done_o` 0, `pass_o` 0, `fail_banks_o` 0, `fail_addr_o` 0, all `mem_*_o` 0, `cmp_vld` 0.
- Reset mid-test: on the next edge, all outputs return to their reset values and no `done_o` is produced.
- Start accepted at cycle 0. Request cycles:
  - WR_PAT: 1..D
  - RD_PAT: D+1..2D
  - WR_INV: 2D+1..3D
  - RD_INV: 3D+1..4D
- FLUSH occurs at 4D+1. `done_o`, final `pass_o`, `busy_o` = 0 and IDLE all occur at 4D+2.
- Back-to-back: `start_i` in the `done_o` cycle is accepted, so the next WR_PAT begins at 4D+3.
- Read latency is fixed at 1 cycle. `mem_rdata_i` is ignored when `cmp_vld` = 0.

## Configuration
- `SNITCH_MEM_BIST_INV_PASS_EN` defined: the full sequence WR_PAT → RD_PAT → WR_INV → RD_INV → FLUSH; `done_o` at 4D+2.
- Undefined: WR_INV and RD_INV are not compiled. RD_PAT moves directly to FLUSH, and `done_o` occurs at 2D+2. No ~P data path exists.

## Test plan
- **Ideal memory**, D = 16, 4 banks, P = 0xA5A5_A5A5_A5A5_A5A5, macro defined: start → `busy_o` high cycles 1–65, `done_o` at cycle 66, `pass_o` = 1, `fail_banks_o` = 0.
- **Single fault:** bank 2 bit 0 stuck-at-1 at address 5, P = 0 → `fail_banks_o` = 4'b0100, `fail_addr_o` = 5, `pass_o` = 0 at `done_o`.
- **Inverse-only fault:** bank 1 bit 63 stuck-at-0 at address 9, P = 0 → mismatch detected only in RD_INV; `fail_banks_o` = 4'b0010, `fail_addr_o` = 9.
- **Ignored start, then clear:** `start_i` pulsed at cycle 20 → ignored, `done_o` still at 66. A new start after a failing run → fail registers cleared at the accept edge.
- **Abort:** `abort_i` at cycle 40 (WR_INV) → `mem_cs_o` = 0 and `busy_o` = 0 from cycle 41, no `done_o`, `pass_o` = 0.
- **Reset and macro-off:** `rst_i` at cycle 25 → all outputs 0 next cycle. Macro undefined, same ideal memory → `done_o` at cycle 34, `pass_o` = 1.

Source files
------------

// File: rtl/snitch_data_mem_bist_if.sv
// Request/response bundle between the BIST initiator (master) and the TCDM banks (slave).
// Every bank field is packed flat, with bank 0 in the least significant slice.
interface snitch_data_mem_bist_if #(
    parameter int unsigned NumTotalBanks   = 32'd32,
    parameter int unsigned AddrWidth       = 32'd10,
    parameter int unsigned NarrowDataWidth = 32'd64
);
    logic [NumTotalBanks-1:0]                     mem_cs;
    logic [NumTotalBanks*AddrWidth-1:0]           mem_add;
    logic [NumTotalBanks-1:0]                     mem_wen;
    logic [NumTotalBanks*(NarrowDataWidth/8)-1:0] mem_be;
    logic [NumTotalBanks*NarrowDataWidth-1:0]     mem_wdata;
    logic [NumTotalBanks*NarrowDataWidth-1:0]     mem_rdata;

    modport master (
        output mem_cs, mem_add, mem_wen, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_cs, mem_add, mem_wen, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/snitch_data_mem_bist.sv
// March-style BIST for the TCDM banks: write P, read P, then optionally write ~P and read ~P in descending order.
// Define SNITCH_MEM_BIST_INV_PASS_EN to build the inverse passes; without it the test ends after the read of P.
module snitch_data_mem_bist #(
    parameter int unsigned TCDMDepth       = 32'd1024,
    parameter int unsigned NarrowDataWidth = 32'd64,
    parameter int unsigned NumTotalBanks   = 32'd32,
    parameter int unsigned AddrWidth       = $clog2(TCDMDepth)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [NarrowDataWidth-1:0] pattern_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [NumTotalBanks-1:0]   fail_banks_o,
    output logic [AddrWidth-1:0]       fail_addr_o,
    snitch_data_mem_bist_if.master     mem
);
    localparam int unsigned BeWidth = NarrowDataWidth / 32'd8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_PAT = 3'd1;
    localparam logic [2:0] RD_PAT = 3'd2;
`ifdef SNITCH_MEM_BIST_INV_PASS_EN
    localparam logic [2:0] WR_INV = 3'd3;
    localparam logic [2:0] RD_INV = 3'd4;
`endif
    localparam logic [2:0] FLUSH  = 3'd5;

    localparam logic [AddrWidth-1:0] AddrZero = {AddrWidth{1'b0}};
    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(32'd1);
    localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(TCDMDepth - 32'd1);

    logic [2:0]                 state_r, state_s;
    logic [AddrWidth-1:0]       addr_r, addr_s;
    logic [NarrowDataWidth-1:0] pat_r;
    logic                       cmp_vld_r;
    logic [NarrowDataWidth-1:0] cmp_exp_r;
    logic [AddrWidth-1:0]       cmp_addr_r;
    logic [NumTotalBanks-1:0]   fail_banks_r;
    logic [AddrWidth-1:0]       fail_addr_r;
    logic                       pass_r;
    logic                       done_r;

    logic                       accept_s;
    logic                       abort_s;
    logic                       wr_s;
    logic                       rd_s;
    logic                       req_s;
    logic [NarrowDataWidth-1:0] word_s;
    logic [NarrowDataWidth-1:0] exp_s;
    logic [NumTotalBanks-1:0]   mismatch_s;

    assign accept_s = (state_r == IDLE) && start_i;
    assign abort_s  = (state_r != IDLE) && abort_i;

    // Next-state and address-counter sequencing; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = WR_PAT;
                    addr_s  = AddrZero;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_PAT: begin
                if (addr_r == AddrLast) begin
                    state_s = RD_PAT;
                    addr_s  = AddrZero;
                end else begin
                    addr_s = addr_r + AddrOne;
                end
            end
            RD_PAT: begin
                if (addr_r == AddrLast) begin
`ifdef SNITCH_MEM_BIST_INV_PASS_EN
                    state_s = WR_INV;
`else
                    state_s = FLUSH;
`endif
                    addr_s  = AddrZero;
                end else begin
                    addr_s = addr_r + AddrOne;
                end
            end
`ifdef SNITCH_MEM_BIST_INV_PASS_EN
            WR_INV: begin
                if (addr_r == AddrLast) begin
                    state_s = RD_INV;
                    addr_s  = AddrLast;
                end else begin
                    addr_s = addr_r + AddrOne;
                end
            end
            // Descending read of ~P catches address-decoder faults the ascending passes miss.
            RD_INV: begin
                if (addr_r == AddrZero) begin
                    state_s = FLUSH;
                    addr_s  = AddrZero;
                end else begin
                    addr_s = addr_r - AddrOne;
                end
            end
`endif
            FLUSH: begin
                state_s = IDLE;
                addr_s  = AddrZero;
            end
            default: begin
                state_s = IDLE;
                addr_s  = AddrZero;
            end
        endcase
        if (abort_s) begin
            state_s = IDLE;
            addr_s  = AddrZero;
        end else begin
            state_s = state_s;
        end
    end

    // Request decode: which phase writes or reads, and the data/expectation for it.
    always_comb begin
        wr_s   = 1'b0;
        rd_s   = 1'b0;
        word_s = {NarrowDataWidth{1'b0}};
        exp_s  = pat_r;
        case (state_r)
            WR_PAT: begin
                wr_s   = 1'b1;
                word_s = pat_r;
            end
            RD_PAT: begin
                rd_s = 1'b1;
            end
`ifdef SNITCH_MEM_BIST_INV_PASS_EN
            WR_INV: begin
                wr_s   = 1'b1;
                word_s = ~pat_r;
            end
            RD_INV: begin
                rd_s  = 1'b1;
                exp_s = ~pat_r;
            end
`endif
            default: begin
                wr_s = 1'b0;
                rd_s = 1'b0;
            end
        endcase
    end

    assign req_s         = wr_s | rd_s;
    assign mem.mem_cs    = {NumTotalBanks{req_s}};
    assign mem.mem_wen   = {NumTotalBanks{wr_s}};
    assign mem.mem_be    = {(NumTotalBanks*BeWidth){req_s}};
    assign mem.mem_add   = {NumTotalBanks{(req_s ? addr_r : AddrZero)}};
    assign mem.mem_wdata = {NumTotalBanks{word_s}};

    // Per-bank compare of the word returned for last cycle's read.
    always_comb begin
        mismatch_s = {NumTotalBanks{1'b0}};
        for (int unsigned i = 0; i < NumTotalBanks; i++) begin
            if (cmp_vld_r && (mem.mem_rdata[i*NarrowDataWidth +: NarrowDataWidth] != cmp_exp_r)) begin
                mismatch_s[i] = 1'b1;
            end else begin
                mismatch_s[i] = 1'b0;
            end
        end
    end

    // State, compare pipeline and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            addr_r       <= AddrZero;
            pat_r        <= {NarrowDataWidth{1'b0}};
            cmp_vld_r    <= 1'b0;
            cmp_exp_r    <= {NarrowDataWidth{1'b0}};
            cmp_addr_r   <= AddrZero;
            fail_banks_r <= {NumTotalBanks{1'b0}};
            fail_addr_r  <= AddrZero;
            pass_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            cmp_vld_r  <= rd_s && !abort_s;
            cmp_exp_r  <= exp_s;
            cmp_addr_r <= addr_r;
            done_r     <= (state_r == FLUSH) && !abort_i;
            if (accept_s) begin
                pat_r        <= pattern_i;
                fail_banks_r <= {NumTotalBanks{1'b0}};
                fail_addr_r  <= AddrZero;
                pass_r       <= 1'b0;
            end else begin
                fail_banks_r <= fail_banks_r | mismatch_s;
                // Only the very first failing word is recorded.
                if ((|mismatch_s) && (fail_banks_r == {NumTotalBanks{1'b0}})) begin
                    fail_addr_r <= cmp_addr_r;
                end else begin
                    fail_addr_r <= fail_addr_r;
                end
                if ((state_r == FLUSH) && !abort_i) begin
                    pass_r <= ~|(fail_banks_r | mismatch_s);
                end else begin
                    pass_r <= pass_r;
                end
            end
        end
    end

    assign busy_o       = (state_r != IDLE);
    assign done_o       = done_r;
    assign pass_o       = pass_r;
    assign fail_banks_o = fail_banks_r;
    assign fail_addr_o  = fail_addr_r;
endmodule
